decode_pipe_buf: RTL and testbench
==================================

Name: decode_pipe_buf

Overview:
- Parametrised decode-stage pipeline buffer between fetch/regfile read and execute; successor to the single-register decode latch.
- Replaces the global stall input with a valid/ready handshake on both sides. Holds up to two instructions (main + skid) so in_ready is registered and throughput is one instruction per cycle.
- Adds synchronous flush, NSRC operand lanes and register-index extraction.

Parameters:
- XLEN, 32, data/PC width in bits.
- NSRC, 2, source operand lanes (1..3); lane 2 uses rs3 = instr[31:27].
- NOP_INSTR, 32'h0000_0013, instruction word presented when no valid entry (addi x0,x0,0).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  kill all buffered entries (branch mispredict/trap).
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  buffer can accept; registered.
- in_pc  in  XLEN  instruction PC.
- in_instr  in  32  instruction word.
- in_src  in  NSRC*XLEN  source operands, lane i at [i*XLEN +: XLEN].
- out_valid  out  1  main entry valid.
- out_ready  in  1  execute accepts main entry.
- out_pc  out  XLEN  PC of main entry.
- out_instr  out  32  instruction of main entry; NOP_INSTR when invalid.
- out_src  out  NSRC*XLEN  operands of main entry.
- out_rs  out  NSRC*5  register indices (rs1=[19:15], rs2=[24:20], rs3=[31:27]) of main entry.
- out_rd  out  5  rd=[11:7] of main entry.

Behaviour:
- Reset (async, rst=1): main_valid=0, skid_valid=0, in_ready=1, out_pc=0, out_instr=NOP_INSTR, out_src=0, out_rs=0, out_rd=0.
- Accept: in_fire = in_valid & in_ready & !flush. Deliver: out_fire = out_valid & out_ready.
- Latency: an entry accepted into an empty buffer, or into one whose main entry is delivered that cycle, appears on out_* the next cycle.
- Main load priority: (1) skid_valid & (out_fire | !main_valid) → main ← skid, skid ← in if in_fire; (2) else in_fire & (out_fire | !main_valid) → main ← in; (3) else in_fire → skid ← in.
- Order is strictly FIFO. An entry is never duplicated or dropped except by flush.
- in_ready next = !skid_valid_next. Upstream may assert in_valid regardless of in_ready; no combinational path from out_ready to in_ready.
- out_rs/out_rd are registered alongside the entry and decoded from the stored instr; lanes ≥ NSRC are absent.
- When out_valid=0: out_instr=NOP_INSTR; other data outputs hold their last values (don't-care).
- Flush (synchronous, highest priority): main_valid and skid_valid ← 0, out_instr ← NOP_INSTR, in_ready ← 1. An input presented during the flush cycle is dropped. out_fire in the flush cycle still counts downstream; the buffer ignores it.
- rst during operation: immediate clear to reset values, independent of clk.
- out_valid must stay high with stable data until out_fire (no retraction).

Optional Feature:
- Macro DECODE_PIPE_WB_BYPASS_EN. Adds ports wb_valid (in, 1), wb_rd (in, 5), wb_data (in, XLEN).
- With macro: each cycle wb_valid & wb_rd≠0 overwrites every stored src lane (main and skid) whose rs equals wb_rd with wb_data. The same patch applies to an entry being loaded that cycle from in_* or from skid, using the incoming rs. out_* show the patched value next cycle.
- Without macro: ports absent; operands pass unmodified.

Decomposition:
- Shared package: XLEN default, NOP_INSTR, reg-index width constant REG_W=5, field-position constants RS1_LSB/RS2_LSB/RS3_LSB/RD_LSB, and a packed struct dec_entry_t {pc, instr, src[NSRC], rs[NSRC], rd}.
- One natural sub-module, dec_entry_reg: single entry register with load enable, clear and optional bypass patch logic. Instantiated twice (main, skid).

Test Plan:
- Reset: assert rst mid-stream with both entries full → out_valid=0, out_instr=32'h13, in_ready=1 immediately, without waiting for a clock edge.
- Streaming: in_valid=1 and out_ready=1 for 8 cycles with PC 0x100,0x104,… → out_pc 0x100.. one cycle later, one per cycle, in_ready stays 1.
- Backpressure: out_ready=0, push PC 0x200, 0x204 → in_ready=0 after second accept. Release out_ready → 0x200 then 0x204 out on consecutive cycles; 0x208 is held until in_ready=1.
- Flush: both entries full, flush=1 with in_valid=1 (PC 0x300) → next cycle out_valid=0, out_instr=NOP_INSTR, in_ready=1; 0x300 never appears.
- Field extraction: instr 32'h00B50533 (add x10,x10,x11) → out_rs lane0=10, lane1=11, out_rd=10. With NSRC=3 and instr[31:27]=5, lane2=5.
- Bypass (macro on): entry rs1=5 held under out_ready=0; wb_valid=1, wb_rd=5, wb_data=0xDEADBEEF → out_src lane0=0xDEADBEEF next cycle. Same write with wb_rd=0 → no change.

Source files
------------

// File: rtl/decode_pipe_buf_pkg.sv
// Shared constants, default entry layout and field helpers for the decode pipeline buffer.
// Optional writeback bypass is enabled by defining DECODE_PIPE_WB_BYPASS_EN.
package decode_pipe_buf_pkg;

    localparam int          XLEN_DEF      = 32;
    localparam int          NSRC_DEF      = 2;
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;
    localparam int          REG_W         = 5;
    localparam int          RD_LSB        = 7;
    localparam int          RS1_LSB       = 15;
    localparam int          RS2_LSB       = 20;
    localparam int          RS3_LSB       = 27;

    // Layout of one buffered entry in the default configuration.
    typedef struct packed {
        logic [XLEN_DEF-1:0]                pc;
        logic [31:0]                        instr;
        logic [NSRC_DEF-1:0][XLEN_DEF-1:0]  src;
        logic [NSRC_DEF-1:0][REG_W-1:0]     rs;
        logic [REG_W-1:0]                   rd;
    } dec_entry_t;

    function automatic int rs_lsb(input int lane);
        return (lane == 0) ? RS1_LSB : (lane == 1) ? RS2_LSB : RS3_LSB;
    endfunction

endpackage

// File: rtl/decode_pipe_buf_if.sv
// Valid/ready bundle between fetch/regfile read (master) and the decode buffer (slave).
interface decode_pipe_buf_if
    import decode_pipe_buf_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NSRC = NSRC_DEF
);
    logic                    in_valid;
    logic                    in_ready;
    logic [XLEN-1:0]         in_pc;
    logic [31:0]             in_instr;
    logic [NSRC*XLEN-1:0]    in_src;
    logic                    out_valid;
    logic                    out_ready;
    logic [XLEN-1:0]         out_pc;
    logic [31:0]             out_instr;
    logic [NSRC*XLEN-1:0]    out_src;
    logic [NSRC*REG_W-1:0]   out_rs;
    logic [REG_W-1:0]        out_rd;

    modport master (
        output in_valid, in_pc, in_instr, in_src, out_ready,
        input  in_ready, out_valid, out_pc, out_instr, out_src, out_rs, out_rd
    );

    modport slave (
        input  in_valid, in_pc, in_instr, in_src, out_ready,
        output in_ready, out_valid, out_pc, out_instr, out_src, out_rs, out_rd
    );
endinterface

// File: rtl/decode_pipe_buf_entry_reg.sv
// One decode entry register: load, clear, hold; patches operands from writeback when
// DECODE_PIPE_WB_BYPASS_EN is defined.
module dec_entry_reg
    import decode_pipe_buf_pkg::*;
#(
    parameter int          XLEN      = XLEN_DEF,
    parameter int          NSRC      = NSRC_DEF,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   ld,
    input  logic                   drop,
    input  logic [XLEN-1:0]        d_pc,
    input  logic [31:0]            d_instr,
    input  logic [NSRC*XLEN-1:0]   d_src,
    input  logic [NSRC*REG_W-1:0]  d_rs,
    input  logic [REG_W-1:0]       d_rd,
`ifdef DECODE_PIPE_WB_BYPASS_EN
    input  logic                   wb_valid,
    input  logic [REG_W-1:0]       wb_rd,
    input  logic [XLEN-1:0]        wb_data,
`endif
    output logic                   q_valid,
    output logic [XLEN-1:0]        q_pc,
    output logic [31:0]            q_instr,
    output logic [NSRC*XLEN-1:0]   q_src,
    output logic [NSRC*REG_W-1:0]  q_rs,
    output logic [REG_W-1:0]       q_rd
);
    typedef struct packed {
        logic [XLEN-1:0]               pc;
        logic [31:0]                   instr;
        logic [NSRC-1:0][XLEN-1:0]     src;
        logic [NSRC-1:0][REG_W-1:0]    rs;
        logic [REG_W-1:0]              rd;
    } entry_t;

    entry_t                     q_reg;
    logic                       valid_reg;
    logic [NSRC-1:0][XLEN-1:0]  d_src_p;
    logic [NSRC-1:0][XLEN-1:0]  hold_src_p;

    generate
        for (genvar gi = 0; gi < NSRC; gi++) begin : g_lane
`ifdef DECODE_PIPE_WB_BYPASS_EN
            // Incoming lanes match on their own rs, held lanes on the stored rs.
            assign d_src_p[gi] = (wb_valid && wb_rd != '0 && d_rs[gi*REG_W +: REG_W] == wb_rd)
                               ? wb_data : d_src[gi*XLEN +: XLEN];
            assign hold_src_p[gi] = (wb_valid && wb_rd != '0 && q_reg.rs[gi] == wb_rd)
                                  ? wb_data : q_reg.src[gi];
`else
            assign d_src_p[gi]    = d_src[gi*XLEN +: XLEN];
            assign hold_src_p[gi] = q_reg.src[gi];
`endif
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_reg     <= 1'b0;
            q_reg         <= '0;
            q_reg.instr   <= NOP_INSTR;
        end else if (clr) begin
            valid_reg     <= 1'b0;
            q_reg.instr   <= NOP_INSTR;
        end else if (ld) begin
            valid_reg     <= 1'b1;
            q_reg.pc      <= d_pc;
            q_reg.instr   <= d_instr;
            q_reg.src     <= d_src_p;
            q_reg.rs      <= d_rs;
            q_reg.rd      <= d_rd;
        end else begin
            if (drop) begin
                valid_reg <= 1'b0;
            end
            q_reg.src     <= hold_src_p;
        end
    end

    assign q_valid = valid_reg;
    assign q_pc    = q_reg.pc;
    assign q_instr = q_reg.instr;
    assign q_src   = q_reg.src;
    assign q_rs    = q_reg.rs;
    assign q_rd    = q_reg.rd;
endmodule

// File: rtl/decode_pipe_buf.sv
// Two-entry (main + skid) decode buffer with registered in_ready and synchronous flush.
// Define DECODE_PIPE_WB_BYPASS_EN to add the writeback operand bypass ports.
module decode_pipe_buf
    import decode_pipe_buf_pkg::*;
#(
    parameter int          XLEN      = XLEN_DEF,
    parameter int          NSRC      = NSRC_DEF,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
`ifdef DECODE_PIPE_WB_BYPASS_EN
    input  logic               wb_valid,
    input  logic [REG_W-1:0]   wb_rd,
    input  logic [XLEN-1:0]    wb_data,
`endif
    decode_pipe_buf_if.slave   bus
);
    logic                   main_valid, skid_valid;
    logic [XLEN-1:0]        main_pc, skid_pc, main_d_pc;
    logic [31:0]            main_instr, skid_instr, main_d_instr;
    logic [NSRC*XLEN-1:0]   main_src, skid_src, main_d_src;
    logic [NSRC*REG_W-1:0]  main_rs, skid_rs, main_d_rs, in_rs;
    logic [REG_W-1:0]       main_rd, skid_rd, main_d_rd, in_rd;
    logic                   in_ready, in_fire, out_fire, main_take;
    logic                   main_ld, main_drop, skid_ld, skid_drop;

    generate
        for (genvar gi = 0; gi < NSRC; gi++) begin : g_rs
            assign in_rs[gi*REG_W +: REG_W] = bus.in_instr[rs_lsb(gi) +: REG_W];
        end
    endgenerate
    assign in_rd = bus.in_instr[RD_LSB +: REG_W];

    // in_ready is the inverted skid flag, so it is a register output with no path from out_ready.
    assign in_ready  = ~skid_valid;
    assign in_fire   = bus.in_valid & in_ready & ~flush;
    assign out_fire  = main_valid & bus.out_ready;
    assign main_take = ~main_valid | out_fire;

    // The skid entry is always older than the input, so it refills main first.
    assign main_ld   = ~flush & main_take & (skid_valid | in_fire);
    assign main_drop = out_fire;
    assign skid_ld   = in_fire & (skid_valid | ~main_take);
    assign skid_drop = skid_valid & main_take;

    assign main_d_pc    = skid_valid ? skid_pc    : bus.in_pc;
    assign main_d_instr = skid_valid ? skid_instr : bus.in_instr;
    assign main_d_src   = skid_valid ? skid_src   : bus.in_src;
    assign main_d_rs    = skid_valid ? skid_rs    : in_rs;
    assign main_d_rd    = skid_valid ? skid_rd    : in_rd;

    dec_entry_reg #(.XLEN(XLEN), .NSRC(NSRC), .NOP_INSTR(NOP_INSTR)) u_main (
        .clk(clk), .rst(rst), .clr(flush), .ld(main_ld), .drop(main_drop),
        .d_pc(main_d_pc), .d_instr(main_d_instr), .d_src(main_d_src),
        .d_rs(main_d_rs), .d_rd(main_d_rd),
`ifdef DECODE_PIPE_WB_BYPASS_EN
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
`endif
        .q_valid(main_valid), .q_pc(main_pc), .q_instr(main_instr),
        .q_src(main_src), .q_rs(main_rs), .q_rd(main_rd)
    );

    dec_entry_reg #(.XLEN(XLEN), .NSRC(NSRC), .NOP_INSTR(NOP_INSTR)) u_skid (
        .clk(clk), .rst(rst), .clr(flush), .ld(skid_ld), .drop(skid_drop),
        .d_pc(bus.in_pc), .d_instr(bus.in_instr), .d_src(bus.in_src),
        .d_rs(in_rs), .d_rd(in_rd),
`ifdef DECODE_PIPE_WB_BYPASS_EN
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
`endif
        .q_valid(skid_valid), .q_pc(skid_pc), .q_instr(skid_instr),
        .q_src(skid_src), .q_rs(skid_rs), .q_rd(skid_rd)
    );

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = main_valid;
    assign bus.out_pc    = main_pc;
    assign bus.out_instr = main_valid ? main_instr : NOP_INSTR;
    assign bus.out_src   = main_src;
    assign bus.out_rs    = main_rs;
    assign bus.out_rd    = main_rd;
endmodule

// File: tb/tb_decode_pipe_buf.sv
// Directed self-checking bench for decode_pipe_buf (NSRC=3 so the rs3 lane is exercised).
module tb_decode_pipe_buf;
    localparam int          XLEN = 32;
    localparam int          NSRC = 3;
    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] ADD  = 32'h00B5_0533;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
`ifdef DECODE_PIPE_WB_BYPASS_EN
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;
`endif
    int n_tests = 0;
    int n_fail  = 0;

    decode_pipe_buf_if #(.XLEN(XLEN), .NSRC(NSRC)) bif ();

    decode_pipe_buf #(.XLEN(XLEN), .NSRC(NSRC), .NOP_INSTR(NOP)) dut (
        .clk(clk),
        .rst(rst),
        .flush(flush),
`ifdef DECODE_PIPE_WB_BYPASS_EN
        .wb_valid(wb_valid),
        .wb_rd(wb_rd),
        .wb_data(wb_data),
`endif
        .bus(bif)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] instr);
        bif.in_valid = v;
        bif.in_pc    = pc;
        bif.in_instr = instr;
        bif.in_src   = {pc + 32'h2, pc + 32'h1, pc};
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bif.out_ready = 1'b0;
        drive(1'b0, 32'h0, NOP);
        step();
        step();
        n_tests += 7;
        if (bif.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid got %0b want 0", bif.out_valid); end
        if (bif.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset in_ready got %0b want 1", bif.in_ready); end
        if (bif.out_instr !== NOP) begin n_fail++; $display("FAIL reset out_instr got %h want %h", bif.out_instr, NOP); end
        if (bif.out_pc !== 32'h0) begin n_fail++; $display("FAIL reset out_pc got %h want 0", bif.out_pc); end
        if (bif.out_src !== '0) begin n_fail++; $display("FAIL reset out_src got %h want 0", bif.out_src); end
        if (bif.out_rs !== '0) begin n_fail++; $display("FAIL reset out_rs got %h want 0", bif.out_rs); end
        if (bif.out_rd !== 5'd0) begin n_fail++; $display("FAIL reset out_rd got %0d want 0", bif.out_rd); end
        $display("[TB] reset released");
        rst = 1'b0;
    endtask

    task automatic test_streaming();
        logic [31:0] exp_pc;
        bif.out_ready = 1'b1;
        drive(1'b1, 32'h100, ADD);
        for (int i = 0; i < 8; i++) begin
            step();
            exp_pc = 32'h100 + 32'(4 * i);
            n_tests += 4;
            if (bif.out_valid !== 1'b1) begin n_fail++; $display("FAIL stream%0d out_valid got %0b want 1", i, bif.out_valid); end
            if (bif.out_pc !== exp_pc) begin n_fail++; $display("FAIL stream%0d out_pc got %h want %h", i, bif.out_pc, exp_pc); end
            if (bif.out_src[31:0] !== exp_pc) begin n_fail++; $display("FAIL stream%0d out_src0 got %h want %h", i, bif.out_src[31:0], exp_pc); end
            if (bif.in_ready !== 1'b1) begin n_fail++; $display("FAIL stream%0d in_ready got %0b want 1", i, bif.in_ready); end
            $display("[TB] stream out pc=%h", bif.out_pc);
            if (i < 7) drive(1'b1, exp_pc + 32'h4, ADD);
            else bif.in_valid = 1'b0;
        end
        step();
        n_tests++;
        if (bif.out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_drain out_valid got %0b want 0", bif.out_valid); end
    endtask

    task automatic test_backpressure();
        bif.out_ready = 1'b0;
        drive(1'b1, 32'h200, ADD);
        step();
        n_tests += 2;
        if (bif.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_first in_ready got %0b want 1", bif.in_ready); end
        if (bif.out_pc !== 32'h200) begin n_fail++; $display("FAIL bp_first out_pc got %h want 200", bif.out_pc); end
        drive(1'b1, 32'h204, ADD);
        step();
        n_tests += 3;
        if (bif.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full in_ready got %0b want 0", bif.in_ready); end
        if (bif.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_full out_valid got %0b want 1", bif.out_valid); end
        if (bif.out_pc !== 32'h200) begin n_fail++; $display("FAIL bp_full out_pc got %h want 200", bif.out_pc); end
        drive(1'b1, 32'h208, ADD);
        bif.out_ready = 1'b1;
        step();
        n_tests += 3;
        if (bif.out_pc !== 32'h204) begin n_fail++; $display("FAIL bp_skid out_pc got %h want 204", bif.out_pc); end
        if (bif.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_skid out_valid got %0b want 1", bif.out_valid); end
        if (bif.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_skid in_ready got %0b want 1", bif.in_ready); end
        $display("[TB] bp out pc=%h", bif.out_pc);
        step();
        n_tests++;
        if (bif.out_pc !== 32'h208) begin n_fail++; $display("FAIL bp_held out_pc got %h want 208", bif.out_pc); end
        $display("[TB] bp out pc=%h", bif.out_pc);
        bif.in_valid = 1'b0;
        step();
        n_tests++;
        if (bif.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain out_valid got %0b want 0", bif.out_valid); end
    endtask

    task automatic test_flush();
        bif.out_ready = 1'b0;
        drive(1'b1, 32'h280, ADD);
        step();
        drive(1'b1, 32'h284, ADD);
        step();
        n_tests++;
        if (bif.in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_full in_ready got %0b want 0", bif.in_ready); end
        flush = 1'b1;
        drive(1'b1, 32'h300, ADD);
        step();
        flush = 1'b0;
        bif.in_valid = 1'b0;
        n_tests += 3;
        if (bif.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush out_valid got %0b want 0", bif.out_valid); end
        if (bif.out_instr !== NOP) begin n_fail++; $display("FAIL flush out_instr got %h want %h", bif.out_instr, NOP); end
        if (bif.in_ready !== 1'b1) begin n_fail++; $display("FAIL flush in_ready got %0b want 1", bif.in_ready); end
        $display("[TB] flush done");
        bif.out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            n_tests++;
            if (bif.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_after%0d out_valid got %0b pc %h want 0", i, bif.out_valid, bif.out_pc); end
        end
    endtask

    task automatic test_fields();
        bif.out_ready = 1'b0;
        drive(1'b1, 32'h400, ADD);
        step();
        bif.in_valid = 1'b0;
        n_tests += 4;
        if (bif.out_rs[4:0] !== 5'd10) begin n_fail++; $display("FAIL field_rs1 got %0d want 10", bif.out_rs[4:0]); end
        if (bif.out_rs[9:5] !== 5'd11) begin n_fail++; $display("FAIL field_rs2 got %0d want 11", bif.out_rs[9:5]); end
        if (bif.out_rs[14:10] !== 5'd0) begin n_fail++; $display("FAIL field_rs3 got %0d want 0", bif.out_rs[14:10]); end
        if (bif.out_rd !== 5'd10) begin n_fail++; $display("FAIL field_rd got %0d want 10", bif.out_rd); end
        $display("[TB] field instr=%h rs=%h rd=%0d", bif.out_instr, bif.out_rs, bif.out_rd);
        bif.out_ready = 1'b1;
        drive(1'b1, 32'h404, 32'h28B5_0533);
        step();
        bif.in_valid = 1'b0;
        n_tests += 3;
        if (bif.out_rs[14:10] !== 5'd5) begin n_fail++; $display("FAIL field_rs3b got %0d want 5", bif.out_rs[14:10]); end
        if (bif.out_rs[9:5] !== 5'd11) begin n_fail++; $display("FAIL field_rs2b got %0d want 11", bif.out_rs[9:5]); end
        if (bif.out_instr !== 32'h28B5_0533) begin n_fail++; $display("FAIL field_instr got %h want 28b50533", bif.out_instr); end
        $display("[TB] field instr=%h rs=%h rd=%0d", bif.out_instr, bif.out_rs, bif.out_rd);
        step();
    endtask

    task automatic test_async_reset();
        bif.out_ready = 1'b0;
        drive(1'b1, 32'h500, ADD);
        step();
        drive(1'b1, 32'h504, ADD);
        step();
        bif.in_valid = 1'b0;
        n_tests++;
        if (bif.in_ready !== 1'b0) begin n_fail++; $display("FAIL arst_full in_ready got %0b want 0", bif.in_ready); end
        #2;
        rst = 1'b1;
        #1;
        n_tests += 3;
        if (bif.out_valid !== 1'b0) begin n_fail++; $display("FAIL arst out_valid got %0b want 0", bif.out_valid); end
        if (bif.out_instr !== NOP) begin n_fail++; $display("FAIL arst out_instr got %h want %h", bif.out_instr, NOP); end
        if (bif.in_ready !== 1'b1) begin n_fail++; $display("FAIL arst in_ready got %0b want 1", bif.in_ready); end
        $display("[TB] async reset applied");
        #1;
        rst = 1'b0;
        step();
        n_tests++;
        if (bif.out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_after out_valid got %0b want 0", bif.out_valid); end
    endtask

`ifdef DECODE_PIPE_WB_BYPASS_EN
    task automatic test_bypass();
        bif.out_ready = 1'b0;
        drive(1'b1, 32'h600, 32'h0002_8533);
        step();
        bif.in_valid = 1'b0;
        n_tests++;
        if (bif.out_src[31:0] !== 32'h600) begin n_fail++; $display("FAIL byp_pre got %h want 600", bif.out_src[31:0]); end
        wb_valid = 1'b1;
        wb_rd    = 5'd5;
        wb_data  = 32'hDEAD_BEEF;
        step();
        n_tests += 2;
        if (bif.out_src[31:0] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL byp_hit got %h want deadbeef", bif.out_src[31:0]); end
        if (bif.out_src[63:32] !== 32'h601) begin n_fail++; $display("FAIL byp_lane1 got %h want 601", bif.out_src[63:32]); end
        wb_rd   = 5'd0;
        wb_data = 32'h1234_5678;
        step();
        n_tests += 2;
        if (bif.out_src[31:0] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL byp_x0 got %h want deadbeef", bif.out_src[31:0]); end
        if (bif.out_src[63:32] !== 32'h601) begin n_fail++; $display("FAIL byp_x0_lane1 got %h want 601", bif.out_src[63:32]); end
        $display("[TB] bypass src0=%h", bif.out_src[31:0]);
        wb_valid = 1'b0;
        bif.out_ready = 1'b1;
        step();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_fields();
        test_async_reset();
`ifdef DECODE_PIPE_WB_BYPASS_EN
        test_bypass();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
